// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - multi-cycle chunked unsigned adder/subtractor with valid/ready handshake
//
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : a, b and sub are valid
//   in_ready   : block can accept operands (high only in IDLE)
//   a, b       : WIDTH-bit unsigned operands
//   sub        : 0 selects a+b, 1 selects a-b
//   out_valid  : res/cout/neg hold a new result
//   out_ready  : consumer accepts the result
//   res        : truncated sum (add) or |a-b| (subtract)
//   cout       : final carry of the chunked addition (1 = no borrow in subtract)
//   neg        : 1 only for subtract with a < b
module addsub_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             neg
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = CHUNK + 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] s;
  logic             rsub;
  logic             carry;
  logic [KW-1:0]    k;

  logic             accept;
  logic             last;
  logic [CHUNK-1:0] ra_chunk;
  logic [CHUNK-1:0] rb_chunk;
  logic [CW-1:0]    chunk_sum;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs. in_ready/out_valid depend on the
  // registered state only, so there is no combinational path from
  // in_valid or out_ready to any output.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (last) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign accept = in_valid && (state == IDLE);
  assign last   = (k == K_LAST);

  // One CHUNK-wide slice of the ripple, carry taken from the previous cycle.
  assign ra_chunk  = ra[k*CHUNK +: CHUNK];
  assign rb_chunk  = rb[k*CHUNK +: CHUNK];
  assign chunk_sum = {1'b0, ra_chunk} + {1'b0, rb_chunk} + CW'(carry);

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra    <= '0;
      rb    <= '0;
      s     <= '0;
      rsub  <= 1'b0;
      carry <= 1'b0;
      k     <= '0;
      res   <= '0;
      cout  <= 1'b0;
      neg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Subtract is a + ~b + 1: invert b here, seed the carry with sub.
            ra    <= a;
            rb    <= b ^ {WIDTH{sub}};
            rsub  <= sub;
            carry <= sub;
            k     <= '0;
          end
        end
        CALC: begin
          s[k*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry               <= chunk_sum[CHUNK];
          if (!last) begin
            k <= k + KW'(1);
          end
        end
        FIX: begin
          cout <= carry;
          // A missing final carry in subtract mode is a borrow: the sum is
          // the two's complement of the magnitude. Add results are never
          // negated, whatever their carry.
          if (rsub && !carry) begin
            res <= ~s + WIDTH'(1);
            neg <= 1'b1;
          end else begin
            res <= s;
            neg <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// tb/tb_addsub_seq.sv - self-checking bench for addsub_seq over several WIDTH/CHUNK configurations
module tb_addsub_seq;

  localparam int NI = 5;
  localparam int WS [NI] = '{8, 8, 8, 8, 16};
  localparam int CS [NI] = '{4, 1, 2, 8, 4};

  logic          clk;
  logic          rst_n;
  logic [NI-1:0] iv;
  logic [NI-1:0] ordy;
  logic [NI-1:0] sb;
  logic [15:0]   av [NI];
  logic [15:0]   bv [NI];
  logic [NI-1:0] ir;
  logic [NI-1:0] ov;
  logic [NI-1:0] co;
  logic [NI-1:0] ng;
  logic [15:0]   rr [NI];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int WG = WS[g];
    localparam int CG = CS[g];
    logic [WG-1:0] r;
    addsub_seq #(.WIDTH(WG), .CHUNK(CG)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .a         (av[g][WG-1:0]),
      .b         (bv[g][WG-1:0]),
      .sub       (sb[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .res       (r),
      .cout      (co[g]),
      .neg       (ng[g])
    );
    assign rr[g] = 16'(r);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic from the operation rules.
  task automatic ref_model(input int w, input logic [15:0] a, input logic [15:0] b, input bit s,
                           output logic [15:0] r, output logic c, output logic n);
    longint unsigned m;
    longint unsigned t;
    m = 64'd1 << w;
    if (!s) begin
      t = longint'(a) + longint'(b);
      r = 16'(t % m);
      c = (t >= m);
      n = 1'b0;
    end else if (a >= b) begin
      r = a - b;
      c = 1'b1;
      n = 1'b0;
    end else begin
      r = b - a;
      c = 1'b0;
      n = 1'b1;
    end
  endtask

  // Issue one operation on instance g with out_ready held high; check
  // latency, outputs and the return to IDLE.
  task automatic run_op(input int g, input logic [15:0] a, input logic [15:0] b, input bit s,
                        input string tag);
    logic [15:0] er;
    logic        ec;
    logic        en;
    int          lat;
    ref_model(WS[g], a, b, s, er, ec, en);
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(ir[g]), 32'd1);
    av[g]   = a;
    bv[g]   = b;
    sb[g]   = s;
    iv[g]   = 1'b1;
    ordy[g] = 1'b1;
    @(posedge clk);
    #1;
    iv[g] = 1'b0;
    lat = 0;
    while (!ov[g] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(WS[g] / CS[g] + 1));
    chk({tag, "_res"}, 32'(rr[g]), 32'(er));
    chk({tag, "_cout"}, 32'(co[g]), 32'(ec));
    chk({tag, "_neg"}, 32'(ng[g]), 32'(en));
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, 32'({ov[g], ir[g]}), 32'b01);
  endtask

  function automatic logic [15:0] pick(input int w);
    logic [15:0] mask;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return mask;
      default: return 16'($urandom) & mask;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    iv    = '0;
    ordy  = '0;
    sb    = '0;
    for (int i = 0; i < NI; i++) begin
      av[i] = '0;
      bv[i] = '0;
    end

    // Reset state, before any clock edge
    #1;
    chk("reset_in_ready", 32'(ir[0]), 32'd1);
    chk("reset_out_valid", 32'(ov[0]), 32'd0);
    chk("reset_res", 32'(rr[0]), 32'd0);
    chk("reset_cout_neg", 32'({co[0], ng[0]}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, WIDTH=8 CHUNK=4
    run_op(0, 16'h3C, 16'h4A, 1'b0, "add_nocarry");
    run_op(0, 16'hF0, 16'h20, 1'b0, "add_carry");
    run_op(0, 16'h50, 16'h20, 1'b1, "sub_pos");
    run_op(0, 16'h20, 16'h50, 1'b1, "sub_neg");
    run_op(0, 16'h00, 16'hFF, 1'b1, "sub_0_ff");
    run_op(0, 16'h77, 16'h77, 1'b1, "sub_equal");

    // Backpressure: result held while out_ready is low and in_valid pulses
    @(negedge clk);
    av[0] = 16'h50; bv[0] = 16'h20; sb[0] = 1'b1; iv[0] = 1'b1; ordy[0] = 1'b0;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    for (int i = 0; i < 100 && !ov[0]; i++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_valid", 32'(ov[0]), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      av[0] = pick(8); bv[0] = pick(8); sb[0] = 1'($urandom); iv[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_hold_valid_ready", 32'({ov[0], ir[0]}), 32'b10);
      chk("bp_hold_res", 32'(rr[0]), 32'h30);
      chk("bp_hold_flags", 32'({co[0], ng[0]}), 32'b10);
    end
    // Release with in_valid still high: the DONE-exit edge must not accept.
    @(negedge clk);
    ordy[0] = 1'b1;
    av[0] = 16'hAA; bv[0] = 16'h11; sb[0] = 1'b0;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    chk("bp_release", 32'({ov[0], ir[0]}), 32'b01);
    chk("bp_res_after", 32'(rr[0]), 32'h30);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    av[0] = 16'h3C; bv[0] = 16'h4A; sb[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    chk("rst_mid_busy", 32'(ir[0]), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_handshake", 32'({ov[0], ir[0]}), 32'b01);
    chk("rst_mid_res", 32'(rr[0]), 32'd0);
    chk("rst_mid_flags", 32'({co[0], ng[0]}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 16'h10, 16'h01, 1'b0, "rst_next");

    // Parameter sweep with random operands
    for (int g = 1; g < NI; g++) begin
      for (int i = 0; i < 1000; i++) begin
        run_op(g, pick(WS[g]), pick(WS[g]), 1'($urandom), $sformatf("sweep_w%0d_c%0d", WS[g], CS[g]));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Parametrised, multi-cycle unsigned adder/subtractor for the ALU datapath, the successor to the fixed 4-bit combinational subtractor.
- Processes `WIDTH`-bit operands `CHUNK` bits per clock with a registered carry.
- In subtract mode, returns the magnitude of the difference plus a sign flag.
- Both sides use a valid/ready handshake, so it can sit between the operand register stage and the result writeback with backpressure.
- Corrects the previous block's behaviour of negating add results when carry-out is 0: negation now happens only in subtract mode.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width. Must be ≥ 2.
- `CHUNK`, default 4: bits added per CALC cycle. Requires 1 ≤ `CHUNK` ≤ `WIDTH` and `WIDTH % CHUNK == 0`. `N = WIDTH/CHUNK`.

Ports:
- `clk`, in, 1: the single clock. All state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `in_valid`, in, 1: operands and `sub` are valid.
- `in_ready`, out, 1: block can accept operands. High only in IDLE.
- `a`, in, `WIDTH`: minuend or augend, unsigned.
- `b`, in, `WIDTH`: subtrahend or addend, unsigned.
- `sub`, in, 1: selects the operation. 0 means `a+b`, 1 means `a-b`.
- `out_valid`, out, 1: result registers hold a new result.
- `out_ready`, in, 1: consumer accepts the result.
- `res`, out, `WIDTH`: sum (add), or |a−b| (subtract).
- `cout`, out, 1: final carry-out of the chunked addition (definition under FIX).
- `neg`, out, 1: 1 only when `sub`=1 and a < b.

## Operation
FSM states: IDLE, CALC, FIX, DONE.
- **IDLE**
  - `in_ready`=1, `out_valid`=0.
  - On `in_valid`&`in_ready`, capture `a` into `ra`, `b ^ {WIDTH{sub}}` into `rb`, and `sub` into `rsub`.
  - Set `carry` = `sub` and chunk index `k` = 0, then go to CALC.
  - `a`, `b` and `sub` are ignored outside this capture edge.
- **CALC**
  - Each cycle computes `{c, s[k*CHUNK +: CHUNK]} = ra[k-chunk] + rb[k-chunk] + carry`, then sets `carry` ← c and `k` ← k+1.
  - After chunk N−1, go to FIX. `k` never wraps past N−1.
- **FIX** (one cycle), registers the outputs:
  - `cout` ← `carry`.
  - If `rsub` & ~`carry`: `res` ← ~s + 1 and `neg` ← 1.
  - Otherwise: `res` ← s and `neg` ← 0.
  - Go to DONE.
- **DONE**
  - `out_valid`=1 and `in_ready`=0. `res`, `cout` and `neg` are held stable.
  - On `out_ready`=1, go to IDLE. While `out_ready`=0, stay.
- Arithmetic rules:
  - Subtract is two's-complement: `a + ~b + 1`. `carry`=1 means no borrow (a ≥ b).
  - The magnitude always fits in `WIDTH` bits. For 0 − (2^WIDTH−1), `res` = 2^WIDTH−1.
  - a == b in subtract gives `res`=0, `cout`=1, `neg`=0.
  - Add overflow is reported only via `cout`=1. `res` is the truncated sum and is never negated.
- Outside FIX, `res`, `cout` and `neg` keep their last values, including after the handshake in IDLE.

## Timing
- **Reset** (`rst_n`=0, asynchronous):
  - State goes to IDLE; `k`, `carry`, `ra`, `rb`, `rsub` go to 0.
  - `res`=0, `cout`=0, `neg`=0, `out_valid`=0, `in_ready`=1.
  - Outputs reach these values without waiting for a clock edge.
- **Reset mid-operation** (CALC, FIX or DONE): the operation is discarded, no result is presented, and `in_ready`=1 after release.
- **Latency:** with the accept edge at t0, the block is in FIX after edge t0+N and `out_valid` rises after edge t0+N+1, i.e. N+1 cycles after accept.
- **Throughput:** at most one operation per N+3 cycles, when `out_ready` is held at 1.
- **Handshake outputs:** `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- **DONE exit:** on the edge where `out_valid`&`out_ready`, the state moves to IDLE. `in_valid` in that same cycle is not accepted; it is accepted next cycle.
- **Edge cases:**
  - `in_valid` asserted while busy has no effect.
  - With `CHUNK`=`WIDTH`, N=1, so CALC lasts one cycle.
  - With `CHUNK`=1, CALC lasts `WIDTH` cycles.

## Test plan
All scenarios use `WIDTH`=8, `CHUNK`=4 unless stated.
- **Add, no carry:** a=0x3C, b=0x4A, sub=0 → `res`=0x86, `cout`=0, `neg`=0, with `out_valid` 3 cycles after accept.
- **Add with carry:** a=0xF0, b=0x20, sub=0 → `res`=0x10, `cout`=1, `neg`=0 (the result is not negated).
- **Subtract:**
  - 0x50−0x20 → `res`=0x30, `cout`=1, `neg`=0.
  - 0x20−0x50 → `res`=0x30, `cout`=0, `neg`=1.
  - 0x00−0xFF → `res`=0xFF, `neg`=1.
  - 0x77−0x77 → `res`=0x00, `cout`=1, `neg`=0.
- **Backpressure:**
  - Hold `out_ready`=0 for 5 cycles while pulsing `in_valid` with new operands → `out_valid`=1, `res` stable and `in_ready`=0 throughout, and the new operands are not captured.
  - Then `out_ready`=1 → IDLE next cycle, `in_ready`=1.
- **Reset:**
  - Drive `rst_n` low mid-CALC → `out_valid`=0 and `in_ready`=1 asynchronously, with all outputs 0.
  - The next operation 0x10+0x01 yields `res`=0x11.
- **Parameter sweep:**
  - `CHUNK`=1, `CHUNK`=2 and `CHUNK`=`WIDTH`=8, plus `WIDTH`=16/`CHUNK`=4: random 1000 operations against a reference model → outputs match, latency is N+1 cycles.
